mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised up/down modulo counter for the Divider datapath and its control FSMs, replacing fixed 4-bit increment-only counting. Provides:
- programmable modulus;
- parallel load;
- wrap or saturate mode;
- registered carry/borrow pulses, so counters can be cascaded or used as iteration/step counters.

## Interface
Parameters:
- WIDTH, 4, count register width; legal range 1..32.
- MODULUS, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- SATURATE, 0, 0 = wrap at the range ends, 1 = hold at the range ends.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- clr_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear, active-high.
- load  input  1  synchronous parallel load, active-high.
- load_val  input  WIDTH  value captured on load.
- increment  input  1  count up one step.
- decrement  input  1  count down one step.
- count  output  WIDTH  current count (registered).
- at_max  output  1  count == MODULUS-1 (decoded from the register).
- at_zero  output  1  count == 0 (decoded from the register).
- carry  output  1  registered one-cycle pulse; an up-step occurred at MODULUS-1.
- borrow  output  1  registered one-cycle pulse; a down-step occurred at 0.
- ovf  output  1  sticky flag; set by any carry or borrow event.

## Operation
- Priority per rising edge: clr_n (async) > clr > load > step.
- clr_n low: count=0, carry=0, borrow=0, ovf=0, immediately and independent of clk.
  - Release is synchronous to the design; no step occurs on the release edge unless clr_n is high before that edge.
- clr=1: count=0, carry=0, borrow=0, ovf=0 on the next edge. load and step are ignored.
- load=1 (clr=0):
  - count=load_val if load_val <= MODULUS-1, else count=MODULUS-1 (clamped).
  - carry=borrow=0; ovf is unchanged.
  - increment/decrement are ignored that cycle.
- Step decode:
  - increment=1, decrement=0: up.
  - increment=0, decrement=1: down.
  - Both set or neither set: hold. count unchanged, carry=borrow=0.
- Up from count < MODULUS-1: count+1.
- Up from count == MODULUS-1:
  - SATURATE=0: count=0.
  - SATURATE=1: count stays MODULUS-1.
  - Either mode: carry=1 for one cycle, ovf=1.
- Down from count > 0: count-1.
- Down from count == 0:
  - SATURATE=0: count=MODULUS-1.
  - SATURATE=1: count stays 0.
  - Either mode: borrow=1 for one cycle, ovf=1.
- carry and borrow are never high together. Each is 0 on every cycle without a qualifying edge event.
- ovf stays 1 until clr or clr_n. load does not clear it.
- Arithmetic: compare and add in WIDTH+1 bits internally so that MODULUS=2^WIDTH does not overflow the comparison. count never holds a value >= MODULUS.
- Cascading: drive the next stage's increment from this stage's carry. The one-cycle registered delay per stage is accepted.

## Timing
- count, carry, borrow and ovf update one cycle after the sampled control inputs (latency 1).
- at_max and at_zero are combinational from the count register; valid in the same cycle as count; no input-to-output combinational path.
- Reset values: count=0, carry=0, borrow=0, ovf=0. Consequently at_zero=1 and at_max=0 after reset.
- clr_n asserted mid-operation: all registers clear asynchronously. A carry or borrow pulse in flight is cut short.
- Back-to-back steps are allowed every cycle; throughput is one step per clock.

## Test plan
Benches use WIDTH=4, MODULUS=10 unless stated.
- **Reset:** pulse clr_n low between edges while count=7 -> count=0, at_zero=1, ovf=0 before the next edge. Hold increment=1 across release -> count=1 after the first edge with clr_n high.
- **Wrap up (SATURATE=0):** 12 consecutive increments from 0 -> count sequence 1..9,0,1,2. carry high only in the cycle after the 9->0 step. ovf=1 from then on. at_max=1 only while count=9.
- **Wrap down / saturate:**
  - SATURATE=0: decrement from 0 -> count=9, borrow pulse, ovf=1.
  - SATURATE=1: decrement at 0 -> count stays 0 with borrow pulse; increment at 9 -> count stays 9 with carry pulse.
- **Load:** load_val=6 with increment=1 -> count=6 and no step that cycle. load_val=13 -> count=9 (clamped). Load with ovf=1 -> ovf stays 1.
- **Priority and simultaneity:**
  - clr=1, load=1, increment=1 together -> count=0, ovf=0.
  - increment=decrement=1 at count=9 -> count holds 9, no carry.
- **Full range:** WIDTH=4, MODULUS=16, 16 increments from 0 -> count returns to 0 with exactly one carry; at_max=1 at count=15.

Source files
------------

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with parallel load, wrap/saturate ends,
// registered carry/borrow pulses and a sticky overflow flag.
module mod_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     SATURATE = 0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             increment,
  input  logic             decrement,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             carry,
  output logic             borrow,
  output logic             ovf
);

  // Range end held one bit wider so MODULUS == 2**WIDTH still compares cleanly.
  localparam longint           MAX_L   = MODULUS - 64'sd1;
  localparam logic [WIDTH:0]   MAX_EXT = MAX_L[WIDTH:0];
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH + 1)'(1'b1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] ZERO_W  = WIDTH'(1'b0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   count_ext_s;
  logic [WIDTH:0]   load_ext_s;
  logic [WIDTH:0]   count_inc_s;
  logic             step_up_s;
  logic             step_dn_s;

  assign count_ext_s = {1'b0, count_q};
  assign load_ext_s  = {1'b0, load_val};
  assign count_inc_s = count_ext_s + ONE_EXT;
  assign step_up_s   = increment & ~decrement;
  assign step_dn_s   = decrement & ~increment;

  // Next-state decode: clr > load > step; both or neither step inputs hold.
  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    ovf_d    = ovf_q;
    if (clr) begin
      count_d = ZERO_W;
      ovf_d   = 1'b0;
    end else if (load) begin
      if (load_ext_s > MAX_EXT) begin
        count_d = MAX_EXT[WIDTH-1:0];
      end else begin
        count_d = load_val;
      end
    end else if (step_up_s) begin
      if (count_ext_s >= MAX_EXT) begin
        carry_d = 1'b1;
        ovf_d   = 1'b1;
        if (SATURATE != 0) begin
          count_d = MAX_EXT[WIDTH-1:0];
        end else begin
          count_d = ZERO_W;
        end
      end else begin
        count_d = count_inc_s[WIDTH-1:0];
      end
    end else if (step_dn_s) begin
      if (count_q == ZERO_W) begin
        borrow_d = 1'b1;
        ovf_d    = 1'b1;
        if (SATURATE != 0) begin
          count_d = ZERO_W;
        end else begin
          count_d = MAX_EXT[WIDTH-1:0];
        end
      end else begin
        count_d = count_q - ONE_W;
      end
    end else begin
      count_d = count_q;
    end
  end

  // State registers; async clear cuts any carry/borrow pulse short.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q  <= ZERO_W;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign count   = count_q;
  assign carry   = carry_q;
  assign borrow  = borrow_q;
  assign ovf     = ovf_q;
  assign at_max  = (count_ext_s == MAX_EXT);
  assign at_zero = (count_q == ZERO_W);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three instances (mod-10 wrap, mod-10 saturate,
// mod-16 wrap) share stimulus and are checked against an integer model.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       increment = 1'b0;
  logic       decrement = 1'b0;

  logic [3:0] obs_cnt [3];
  logic       obs_max [3];
  logic       obs_zero[3];
  logic       obs_car [3];
  logic       obs_bor [3];
  logic       obs_ovf [3];

  int m_mod [3] = '{10, 10, 16};
  int m_sat [3] = '{0, 1, 0};
  int m_cnt [3];
  int m_car [3];
  int m_bor [3];
  int m_ovf [3];

  int compared = 0;
  int mismatched = 0;
  int full_carries;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_wrap (
    .clk(clk), .clr_n(clr_n), .clr(clr), .load(load), .load_val(load_val),
    .increment(increment), .decrement(decrement), .count(obs_cnt[0]),
    .at_max(obs_max[0]), .at_zero(obs_zero[0]), .carry(obs_car[0]),
    .borrow(obs_bor[0]), .ovf(obs_ovf[0]));

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
    .clk(clk), .clr_n(clr_n), .clr(clr), .load(load), .load_val(load_val),
    .increment(increment), .decrement(decrement), .count(obs_cnt[1]),
    .at_max(obs_max[1]), .at_zero(obs_zero[1]), .carry(obs_car[1]),
    .borrow(obs_bor[1]), .ovf(obs_ovf[1]));

  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_full (
    .clk(clk), .clr_n(clr_n), .clr(clr), .load(load), .load_val(load_val),
    .increment(increment), .decrement(decrement), .count(obs_cnt[2]),
    .at_max(obs_max[2]), .at_zero(obs_zero[2]), .carry(obs_car[2]),
    .borrow(obs_bor[2]), .ovf(obs_ovf[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_car[i] = 0; m_bor[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // One clock edge of the counter rules, applied to every model instance.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      m_car[i] = 0;
      m_bor[i] = 0;
      if (clr) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > m_mod[i] - 1) ? m_mod[i] - 1 : int'(load_val);
      end else if (increment && !decrement) begin
        if (m_cnt[i] == m_mod[i] - 1) begin
          m_car[i] = 1; m_ovf[i] = 1;
          if (m_sat[i] == 0) m_cnt[i] = 0;
        end else m_cnt[i] = m_cnt[i] + 1;
      end else if (decrement && !increment) begin
        if (m_cnt[i] == 0) begin
          m_bor[i] = 1; m_ovf[i] = 1;
          if (m_sat[i] == 0) m_cnt[i] = m_mod[i] - 1;
        end else m_cnt[i] = m_cnt[i] - 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s[%0d].count", tag, i), int'(obs_cnt[i]), m_cnt[i]);
      chk($sformatf("%s[%0d].carry", tag, i), int'(obs_car[i]), m_car[i]);
      chk($sformatf("%s[%0d].borrow", tag, i), int'(obs_bor[i]), m_bor[i]);
      chk($sformatf("%s[%0d].ovf", tag, i), int'(obs_ovf[i]), m_ovf[i]);
      chk($sformatf("%s[%0d].at_max", tag, i), int'(obs_max[i]),
          (m_cnt[i] == m_mod[i] - 1) ? 1 : 0);
      chk($sformatf("%s[%0d].at_zero", tag, i), int'(obs_zero[i]),
          (m_cnt[i] == 0) ? 1 : 0);
    end
  endtask

  task automatic step(input logic inc, input logic dec, input logic ld,
                      input logic c, input logic [3:0] val, input string tag);
    @(negedge clk);
    increment = inc; decrement = dec; load = ld; clr = c; load_val = val;
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk);
    clr_n = 1'b1;

    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "wrap_up");

    // Async clear between edges, with increment held across the release.
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd7, "load7");
    @(negedge clk);
    increment = 1'b1; load = 1'b0;
    #2 clr_n = 1'b0;
    model_reset();
    #1 check_all("async_clr");
    @(posedge clk);
    #1 check_all("async_hold");
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1 check_all("release_step");

    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, "clr");
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "down_from0");
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "idle");
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, "load6_inc");
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd13, "load13");
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "up_at_max");
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd9, "load9");
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "both_hold");
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, "clr_prio");

    full_carries = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "full_range");
      if (obs_car[2] === 1'b1) full_carries++;
    end
    chk("full_range_carries", full_carries, 1);

    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0),
           4'($urandom_range(0, 15)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
